// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: request-unit state encoding and watchdog sizing.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DMEM   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    localparam int WDOG_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer for the single-cycle datapath: fetch/data arbitration,
// sticky halt, performance counters and a data-access watchdog.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WDOG_CYC = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             DataRead,
    input  logic             DataWrite,
    input  logic             Halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcEn,
    output logic             halt,
    output logic             wdog_err,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stalls
);

    // Watchdog fires when the WDOG_CYC-th dhit-less DMEM cycle is under way.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    reqstate_t          state_q, state_d;
    logic               ren_q, ren_d;
    logic               wen_q, wen_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               halt_q, halt_d;
    logic               werr_q, werr_d;
    logic               inc_retired;
    logic               inc_stall;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdog_q  <= '0;
            halt_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            wdog_q  <= wdog_d;
            halt_q  <= halt_d;
            werr_q  <= werr_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        wdog_d      = wdog_q;
        halt_d      = halt_q;
        werr_d      = werr_q;
        imemREN     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        pcEn        = 1'b0;
        inc_retired = 1'b0;
        inc_stall   = 1'b0;

        unique case (state_q)
            FETCH: begin
                imemREN = 1'b1;
                if (!ihit) begin
                    inc_stall = 1'b1;
                end else if (Halt) begin
                    state_d     = HALTED;
                    halt_d      = 1'b1;
                    inc_retired = 1'b1;
                end else if (DataRead || DataWrite) begin
                    // A decode with both flags set is treated as a write.
                    state_d = DMEM;
                    wen_d   = DataWrite;
                    ren_d   = DataRead && !DataWrite;
                    wdog_d  = '0;
                end else begin
                    pcEn        = 1'b1;
                    inc_retired = 1'b1;
                end
            end

            DMEM: begin
                dmemREN = ren_q;
                dmemWEN = wen_q;
                if (dhit) begin
                    pcEn        = 1'b1;
                    inc_retired = 1'b1;
                    ren_d       = 1'b0;
                    wen_d       = 1'b0;
                    state_d     = FETCH;
                end else begin
                    inc_stall = 1'b1;
                    wdog_d    = wdog_q + WDOG_W'(1);
                    if (wdog_q == WDOG_LAST) begin
                        werr_d  = 1'b1;
                        halt_d  = 1'b1;
                        ren_d   = 1'b0;
                        wen_d   = 1'b0;
                        state_d = HALTED;
                    end
                end
            end

            HALTED: begin
                halt_d = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign halt     = halt_q;
    assign wdog_err = werr_q;

    sat_counter #(.W(CNT_W)) u_retired (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (inc_retired),
        .count (retired)
    );

    sat_counter #(.W(CNT_W)) u_stalls (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (inc_stall),
        .count (stalls)
    );

endmodule

// File: tb/tb_request_unit.sv
// Directed self-checking bench for request_unit; small counters expose saturation.
module tb_request_unit;

    localparam int CNT_W    = 3;
    localparam int WDOG_CYC = 4;

    logic             CLK;
    logic             nRST;
    logic             DataRead;
    logic             DataWrite;
    logic             Halt;
    logic             ihit;
    logic             dhit;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pcEn;
    logic             halt;
    logic             wdog_err;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stalls;

    int n_cmp  = 0;
    int n_fail = 0;

    request_unit #(.CNT_W(CNT_W), .WDOG_CYC(WDOG_CYC)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .DataRead  (DataRead),
        .DataWrite (DataWrite),
        .Halt      (Halt),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemREN   (imemREN),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .pcEn      (pcEn),
        .halt      (halt),
        .wdog_err  (wdog_err),
        .retired   (retired),
        .stalls    (stalls)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle; returns just after the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic i_hit, input logic d_hit, input logic rd,
                         input logic wr, input logic h);
        ihit      = i_hit;
        dhit      = d_hit;
        DataRead  = rd;
        DataWrite = wr;
        Halt      = h;
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        ihit = 1'b0; dhit = 1'b0; DataRead = 1'b0; DataWrite = 1'b0; Halt = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        check("rst_imemren", imemREN, 1);
        check("rst_dmemren", dmemREN, 0);
        check("rst_dmemwen", dmemWEN, 0);
        check("rst_halt",    halt,    0);
        check("rst_wdog",    wdog_err, 0);
        check("rst_retired", retired, 0);
        check("rst_stalls",  stalls,  0);
        nRST = 1'b1;

        // ALU stream: five back-to-back fetches, each advances the PC.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0);
            check($sformatf("alu_pcen_%0d", i), pcEn, 1);
            tick();
        end

        // Load issued on the sixth fetch.
        drive(1, 0, 1, 0, 0);
        check("alu_retired",  retired, 5);
        check("alu_stalls",   stalls,  0);
        check("ld_fetch_pc",  pcEn,    0);
        check("ld_fetch_ren", imemREN, 1);
        tick();

        drive(0, 0, 0, 0, 0);
        check("ld_dmemren", dmemREN, 1);
        check("ld_imemren", imemREN, 0);
        check("ld_dmemwen", dmemWEN, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        check("ld_ihit_ignored", pcEn, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();

        // dhit in the 4th DMEM cycle: completion beats the watchdog.
        drive(0, 1, 0, 0, 0);
        check("ld_dhit_pcen",    pcEn,    1);
        check("ld_stalls",       stalls,  3);
        check("ld_retired_pre",  retired, 5);
        tick();

        // Back in FETCH; issue the illegal read+write decode right away.
        drive(1, 0, 1, 1, 0);
        check("ld_back_imemren", imemREN, 1);
        check("ld_back_dmemren", dmemREN, 0);
        check("ld_retired",      retired, 6);
        check("ld_wdog_clear",   wdog_err, 0);
        check("ill_fetch_pcen",  pcEn,    0);
        tick();

        drive(0, 1, 0, 0, 0);
        check("ill_dmemwen", dmemWEN, 1);
        check("ill_dmemren", dmemREN, 0);
        check("ill_imemren", imemREN, 0);
        check("ill_pcen",    pcEn,    1);
        tick();

        // Retired reaches all-ones (7) and must stick there.
        drive(1, 0, 0, 0, 0);
        check("sat_retired_7", retired, 7);
        tick();
        drive(1, 0, 0, 0, 0);
        check("sat_retired_hold", retired, 7);
        tick();

        // Reset in the middle of a load.
        drive(1, 0, 1, 0, 0);
        check("sat_stalls", stalls, 3);
        tick();
        drive(0, 0, 0, 0, 0);
        check("mid_dmemren_pre", dmemREN, 1);
        #1;
        nRST = 1'b0;
        #1;
        check("mid_rst_dmemren", dmemREN, 0);
        check("mid_rst_imemren", imemREN, 1);
        check("mid_rst_halt",    halt,    0);
        check("mid_rst_retired", retired, 0);
        check("mid_rst_stalls",  stalls,  0);
        tick();
        nRST = 1'b1;

        // Store that never completes: watchdog fires after four DMEM cycles.
        drive(1, 0, 0, 1, 0);
        check("wd_fetch_pcen", pcEn, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("wd_wen_%0d", i),  dmemWEN,  1);
            check($sformatf("wd_err_%0d", i),  wdog_err, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        check("wd_err",     wdog_err, 1);
        check("wd_halt",    halt,     1);
        check("wd_dmemwen", dmemWEN,  0);
        check("wd_imemren", imemREN,  0);
        check("wd_stalls",  stalls,   4);
        check("wd_retired", retired,  0);

        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0);
            check($sformatf("wd_halted_pcen_%0d", i), pcEn, 0);
            tick();
        end
        check("wd_frozen_retired", retired, 0);
        check("wd_frozen_stalls",  stalls,  4);
        check("wd_still_halted",   halt,    1);

        // Only reset leaves HALTED.
        nRST = 1'b0;
        #1;
        check("wd_rst_halt", halt,     0);
        check("wd_rst_err",  wdog_err, 0);
        check("wd_rst_imem", imemREN,  1);
        tick();
        nRST = 1'b1;

        // HALT instruction.
        drive(1, 0, 0, 0, 1);
        check("h_fetch_pcen", pcEn, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("h_halt",     halt,     1);
        check("h_retired",  retired,  1);
        check("h_imemren",  imemREN,  0);
        check("h_wdog",     wdog_err, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0);
            check($sformatf("h_pulse_pcen_%0d", i), pcEn, 0);
            tick();
        end
        check("h_frozen_retired", retired, 1);
        check("h_frozen_stalls",  stalls,  0);
        check("h_dmemren",        dmemREN, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
